// File: rtl/adder_sweep_ctrl.sv
// Operand sequencer for the AdderLEDs datapath: sweeps every operand pair at a fixed dwell
// or passes switches through, and counts adder results that disagree with a reference sum.
module adder_sweep_ctrl #(
    parameter int WIDTH        = 2,
    parameter int DWELL_CYCLES = 50
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               step,
    input  logic               mode,
    input  logic [WIDTH-1:0]   sw_a,
    input  logic [WIDTH-1:0]   sw_b,
    input  logic [WIDTH:0]     sum_in,
    output logic [WIDTH-1:0]   sayi1,
    output logic [WIDTH-1:0]   sayi2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH:0]   err_cnt
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0]   OP_MAX   = '1;
    localparam logic [WIDTH-1:0]   OP_ONE   = WIDTH'(1);
    localparam logic [2*WIDTH:0]   ERR_ONE  = (2*WIDTH+1)'(1);
    localparam logic [2*WIDTH:0]   ERR_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [WIDTH-1:0]   sayi1_nxt;
    logic [WIDTH-1:0]   sayi2_nxt;
    logic [2*WIDTH:0]   err_nxt;
    logic [WIDTH:0]     ref_sum;
    logic               mismatch;
    logic               at_last;
    logic [WIDTH-1:0]   adv1;
    logic [WIDTH-1:0]   adv2;
    logic [2*WIDTH:0]   err_checked;

    // Reference sum and the "next combination" with sayi1 as the fast-moving index.
    assign ref_sum     = {1'b0, sayi1} + {1'b0, sayi2};
    assign mismatch    = (sum_in != ref_sum);
    assign err_checked = (mismatch && (err_cnt != ERR_MAX)) ? err_cnt + ERR_ONE : err_cnt;
    assign at_last     = (sayi1 == OP_MAX) && (sayi2 == OP_MAX);
    assign adv1        = (sayi1 == OP_MAX) ? '0 : sayi1 + OP_ONE;
    assign adv2        = (sayi1 == OP_MAX) ? sayi2 + OP_ONE : sayi2;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sayi1_nxt = sayi1;
        sayi2_nxt = sayi2;
        err_nxt   = err_cnt;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    sayi1_nxt = '0;
                    sayi2_nxt = '0;
                    err_nxt   = '0;
                end else if (mode) begin
                    sayi1_nxt = sw_a;
                    sayi2_nxt = sw_b;
                end
            end

            // Pause takes precedence over dwell expiry so a held combination is never checked early.
            ST_RUN: begin
                if (pause) begin
                    state_nxt = ST_HOLD;
                end else if (cnt == CNT_LAST) begin
                    err_nxt = err_checked;
                    cnt_nxt = '0;
                    if (at_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        sayi1_nxt = adv1;
                        sayi2_nxt = adv2;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            ST_HOLD: begin
                if (!pause) begin
                    state_nxt = ST_RUN;
                end else if (step) begin
                    err_nxt = err_checked;
                    cnt_nxt = '0;
                    if (at_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        sayi1_nxt = adv1;
                        sayi2_nxt = adv2;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                    sayi1_nxt = '0;
                    sayi2_nxt = '0;
                    err_nxt   = '0;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // busy/done are flopped from the next state so every output comes straight off a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sayi1   <= '0;
            sayi2   <= '0;
            err_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            sayi1   <= sayi1_nxt;
            sayi2   <= sayi2_nxt;
            err_cnt <= err_nxt;
            busy    <= (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
            done    <= (state_nxt == ST_DONE);
        end
    end

endmodule
